amns_bram_host_port: RTL

AMNS_BRAM_HOST_PORT -- requirements
Module: amns_bram_host_port

---
 rtl/amns_bram_host_port_if.sv | 29 ++
 rtl/amns_bram_host_port.sv | 129 ++++++++++++
 2 files changed

// File: rtl/amns_bram_host_port_if.sv
// Signal bundle for the AMNS BRAM host port: operand stream, result stream,
// core handshake and BRAM port, with views for the block and its environment.
interface amns_bram_host_port_if #(
    parameter int WORD_WIDTH = 17
);
    logic [WORD_WIDTH-1:0] s_data;
    logic                  s_valid;
    logic                  s_ready;
    logic [WORD_WIDTH-1:0] m_data;
    logic                  m_valid;
    logic                  m_ready;
    logic                  core_start;
    logic                  core_done;
    logic                  bram_en;
    logic                  bram_we;
    logic [31:0]           bram_addr;
    logic [WORD_WIDTH-1:0] bram_din;
    logic [WORD_WIDTH-1:0] bram_dout;

    modport slave (
        input  s_data, s_valid, m_ready, core_done, bram_dout,
        output s_ready, m_data, m_valid, core_start, bram_en, bram_we, bram_addr, bram_din
    );

    modport master (
        output s_data, s_valid, m_ready, core_done, bram_dout,
        input  s_ready, m_data, m_valid, core_start, bram_en, bram_we, bram_addr, bram_din
    );
endinterface

// File: rtl/amns_bram_host_port.sv
// Host-side sequencer for an AMNS multiplier: streams operands into BRAM,
// kicks the core, then streams the result region back out one word at a time.
module amns_bram_host_port #(
    parameter int WORD_WIDTH = 17,
    parameter int N          = 5,
    parameter int S          = 4
) (
    input  logic                  clock_i,
    input  logic                  reset_i,
    input  logic [WORD_WIDTH-1:0] s_data_i,
    input  logic                  s_valid_i,
    output logic                  s_ready_o,
    output logic [WORD_WIDTH-1:0] m_data_o,
    output logic                  m_valid_o,
    input  logic                  m_ready_i,
    output logic                  core_start_o,
    input  logic                  core_done_i,
    output logic                  bram_en_o,
    output logic                  bram_we_o,
    output logic [31:0]           bram_addr_o,
    output logic [WORD_WIDTH-1:0] bram_din_o,
    input  logic [WORD_WIDTH-1:0] bram_dout_i
);
    localparam int NS = N * S;
    localparam int CW = $clog2(5 * NS);
    localparam logic [CW-1:0] LAST_WR  = CW'(4 * NS - 1);
    localparam logic [CW-1:0] LAST_RD  = CW'(NS - 1);
    localparam logic [31:0]   RES_BASE = 32'(4 * NS);

    typedef enum logic [2:0] {
        IDLE, WRITE, START, WAIT, READ_ISSUE, READ_WAIT, OUT
    } state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         wr_cnt_q, wr_cnt_d;
    logic [CW-1:0]         rd_cnt_q, rd_cnt_d;
    logic [WORD_WIDTH-1:0] m_data_d;
    logic                  m_valid_d;
    logic                  s_hs;

    // Ready is gated by reset so it is low for the whole reset window and
    // rises as soon as reset releases.
    assign s_ready_o = reset_i && (state_q == IDLE || state_q == WRITE);
    assign s_hs      = s_valid_i && s_ready_o;

    // NOTE: every state element uses non-blocking assignment so all flops
    // update together at the edge, regardless of statement order.
    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q   <= IDLE;
            wr_cnt_q  <= '0;
            rd_cnt_q  <= '0;
            m_data_o  <= '0;
            m_valid_o <= 1'b0;
        end else begin
            state_q   <= state_d;
            wr_cnt_q  <= wr_cnt_d;
            rd_cnt_q  <= rd_cnt_d;
            m_data_o  <= m_data_d;
            m_valid_o <= m_valid_d;
        end
    end

    // NOTE: all outputs of this block get a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d      = state_q;
        wr_cnt_d     = wr_cnt_q;
        rd_cnt_d     = rd_cnt_q;
        m_data_d     = m_data_o;
        m_valid_d    = m_valid_o;
        core_start_o = 1'b0;
        bram_en_o    = 1'b0;
        bram_we_o    = 1'b0;
        bram_addr_o  = '0;
        bram_din_o   = '0;

        unique case (state_q)
            IDLE: begin
                if (s_hs) begin
                    bram_en_o  = 1'b1;
                    bram_we_o  = 1'b1;
                    bram_din_o = s_data_i;
                    wr_cnt_d   = CW'(1);
                    state_d    = WRITE;
                end
            end
            WRITE: begin
                if (s_hs) begin
                    bram_en_o   = 1'b1;
                    bram_we_o   = 1'b1;
                    bram_addr_o = 32'(wr_cnt_q);
                    bram_din_o  = s_data_i;
                    wr_cnt_d    = wr_cnt_q + 1'b1;
                    if (wr_cnt_q == LAST_WR) state_d = START;
                end
            end
            START: begin
                core_start_o = 1'b1;
                state_d      = WAIT;
            end
            WAIT: begin
                if (core_done_i) begin
                    rd_cnt_d = '0;
                    state_d  = READ_ISSUE;
                end
            end
            READ_ISSUE: begin
                bram_en_o   = 1'b1;
                bram_addr_o = RES_BASE + 32'(rd_cnt_q);
                state_d     = READ_WAIT;
            end
            READ_WAIT: begin
                // BRAM read data lands exactly one cycle after the enable.
                m_data_d  = bram_dout_i;
                m_valid_d = 1'b1;
                state_d   = OUT;
            end
            OUT: begin
                if (m_ready_i) begin
                    rd_cnt_d  = rd_cnt_q + 1'b1;
                    m_valid_d = 1'b0;
                    state_d   = (rd_cnt_q == LAST_RD) ? IDLE : READ_ISSUE;
                end
            end
            default: state_d = IDLE;
        endcase
    end
endmodule
